// File: rtl/icache_refill_pkg.sv
// Shared configuration types and FSM state encoding for the I-cache refill engine.
package icache_refill_pkg;

  typedef struct packed {
    int unsigned PLEN;
    int unsigned ICACHE_LINE_WIDTH;
    int unsigned ICACHE_SET_ASSOC;
    int unsigned ICACHE_SET_ASSOC_WIDTH;
    int unsigned ICACHE_INDEX_WIDTH;
    int unsigned ICACHE_TAG_WIDTH;
    int unsigned ICACHE_OFFSET_WIDTH;
  } cfg_t;

  // Derives all I-cache field widths from the physical address width and geometry.
  function automatic cfg_t build_config(input int unsigned plen, input int unsigned line_width,
                                        input int unsigned size_bytes, input int unsigned assoc);
    cfg_t c;
    c.PLEN                   = plen;
    c.ICACHE_LINE_WIDTH      = line_width;
    c.ICACHE_SET_ASSOC       = assoc;
    c.ICACHE_SET_ASSOC_WIDTH = (assoc > 1) ? $clog2(assoc) : 1;
    c.ICACHE_OFFSET_WIDTH    = $clog2(line_width / 8);
    c.ICACHE_INDEX_WIDTH     = $clog2(size_bytes / assoc / (line_width / 8));
    c.ICACHE_TAG_WIDTH       = plen - c.ICACHE_INDEX_WIDTH - c.ICACHE_OFFSET_WIDTH;
    return c;
  endfunction

  localparam cfg_t DefaultCfg = build_config(32, 256, 4096, 4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RECV  = 2'd2,
    WRITE = 2'd3
  } icache_refill_state_e;

endpackage

// File: rtl/icache_line_assembler.sv
// Beat counter plus shift-in line register: beats arrive lowest address first and
// are shifted in from the top, so after BEATS pushes beat 0 sits in the low slice.
module icache_line_assembler #(
  parameter int unsigned BEATS     = 4,
  parameter int unsigned BUS_WIDTH = 64,
  localparam int unsigned LINE_WIDTH = BEATS * BUS_WIDTH,
  localparam int unsigned CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic [BUS_WIDTH-1:0]  data_i,
  output logic [LINE_WIDTH-1:0] line_o,
  output logic                  full_o
);

  logic [CNT_W-1:0]      cnt_q;
  logic [LINE_WIDTH-1:0] line_q;
  logic [LINE_WIDTH-1:0] line_shift;

  if (BEATS > 1) begin : g_shift
    assign line_shift = {data_i, line_q[LINE_WIDTH-1:BUS_WIDTH]};
  end else begin : g_single
    assign line_shift = data_i;
  end

  // full_o marks that the next accepted beat completes the line
  assign full_o = (cnt_q == CNT_W'(BEATS - 1));
  assign line_o = line_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else if (push_i) begin
      cnt_q  <= full_o ? '0 : cnt_q + CNT_W'(1);
      line_q <= line_shift;
    end
  end

endmodule

// File: rtl/icache_refill.sv
// I-cache miss-refill engine: one miss at a time, line-aligned burst read, single-cycle
// array write. Optional performance counters are enabled by ICACHE_REFILL_PERF_EN.
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter cfg_t        Cfg       = DefaultCfg,
  parameter int unsigned BUS_WIDTH = 64
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  miss_valid_i,
  output logic                                  miss_ready_o,
  input  logic [Cfg.PLEN-1:0]                   miss_paddr_i,
  input  logic [Cfg.ICACHE_SET_ASSOC_WIDTH-1:0] miss_way_i,
  input  logic                                  flush_i,
  output logic                                  mem_req_valid_o,
  input  logic                                  mem_req_ready_i,
  output logic [Cfg.PLEN-1:0]                   mem_req_addr_o,
  input  logic                                  mem_rsp_valid_i,
  output logic                                  mem_rsp_ready_o,
  input  logic [BUS_WIDTH-1:0]                  mem_rsp_data_i,
  input  logic                                  mem_rsp_last_i,
  input  logic                                  mem_rsp_err_i,
  output logic                                  refill_we_o,
  output logic [Cfg.ICACHE_INDEX_WIDTH-1:0]     refill_index_o,
  output logic [Cfg.ICACHE_SET_ASSOC_WIDTH-1:0] refill_way_o,
  output logic [Cfg.ICACHE_TAG_WIDTH-1:0]       refill_tag_o,
  output logic [Cfg.ICACHE_LINE_WIDTH-1:0]      refill_data_o,
  output logic                                  refill_done_o,
`ifdef ICACHE_REFILL_PERF_EN
  output logic [31:0]                           perf_refill_cnt_o,
  output logic [31:0]                           perf_stall_cycles_o,
`endif
  output logic                                  refill_err_o
);

  localparam int unsigned PLEN     = Cfg.PLEN;
  localparam int unsigned LINE_W   = Cfg.ICACHE_LINE_WIDTH;
  localparam int unsigned INDEX_W  = Cfg.ICACHE_INDEX_WIDTH;
  localparam int unsigned WAY_W    = Cfg.ICACHE_SET_ASSOC_WIDTH;
  localparam int unsigned OFFSET_W = Cfg.ICACHE_OFFSET_WIDTH;
  localparam int unsigned BEATS    = LINE_W / BUS_WIDTH;

  localparam logic [PLEN-1:0] LINE_MASK = ~((PLEN'(1) << OFFSET_W) - PLEN'(1));

  icache_refill_state_e state_q, state_d;

  logic [PLEN-1:0]  paddr_q;
  logic [WAY_W-1:0] way_q;
  logic             abort_q;
  logic             err_q;

  logic miss_acc;
  logic beat_acc;
  logic beat_full;
  logic beat_bad;

  assign miss_acc = miss_valid_i && (state_q == IDLE);
  assign beat_acc = mem_rsp_valid_i && (state_q == RECV);
  // a beat is bad on a bus error or when the last marker disagrees with the counter
  assign beat_bad = mem_rsp_err_i || (mem_rsp_last_i != beat_full);

  icache_line_assembler #(
    .BEATS     (BEATS),
    .BUS_WIDTH (BUS_WIDTH)
  ) u_line_asm (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (miss_acc),
    .push_i  (beat_acc),
    .data_i  (mem_rsp_data_i),
    .line_o  (refill_data_o),
    .full_o  (beat_full)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (miss_valid_i) state_d = REQ;
      REQ:     if (mem_req_ready_i) state_d = RECV;
      RECV:    if (beat_acc && beat_full) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    miss_ready_o    = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_rsp_ready_o = 1'b0;
    refill_we_o     = 1'b0;
    refill_done_o   = 1'b0;
    refill_err_o    = 1'b0;
    unique case (state_q)
      IDLE:  miss_ready_o    = 1'b1;
      REQ:   mem_req_valid_o = 1'b1;
      RECV:  mem_rsp_ready_o = 1'b1;
      WRITE: begin
        // a flush arriving in the WRITE cycle itself still cancels the write
        if (err_q) begin
          refill_err_o = 1'b1;
        end else if (!(abort_q || flush_i)) begin
          refill_we_o   = 1'b1;
          refill_done_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      paddr_q <= '0;
      way_q   <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (miss_acc) begin
      paddr_q <= miss_paddr_i;
      way_q   <= miss_way_i;
      abort_q <= flush_i;
      err_q   <= 1'b0;
    end else begin
      if (flush_i && (state_q != IDLE)) abort_q <= 1'b1;
      if (beat_acc && beat_bad)         err_q   <= 1'b1;
    end
  end

  assign mem_req_addr_o = paddr_q & LINE_MASK;
  assign refill_index_o = paddr_q[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign refill_tag_o   = paddr_q[PLEN-1:OFFSET_W+INDEX_W];
  assign refill_way_o   = way_q;

`ifdef ICACHE_REFILL_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_refill_cnt_o   <= '0;
      perf_stall_cycles_o <= '0;
    end else begin
      if (refill_done_o) perf_refill_cnt_o <= perf_refill_cnt_o + 32'd1;
      if ((state_q == REQ) || (state_q == RECV)) perf_stall_cycles_o <= perf_stall_cycles_o + 32'd1;
    end
  end
`endif

endmodule
